// File: rtl/sccb_pkg.sv
// sccb_pkg: types and constants shared by the SCCB configuration sequencer and
// the SCCB write engine.
//   seq_state_e     sequencer state encoding
//   DELAY_TAG       bits[31:24] value marking a delay entry (SCCB_CFG_DELAY_EN builds)
//   *_MSB / *_LSB   field slices of a 32-bit table word: TAG, ID, REG, DATA
// Optional feature macro: SCCB_CFG_DELAY_EN (adds the StDelay state).
package sccb_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StBoot,
      StFetch,
      StIssue,
      StWaitAck,
      StWaitEnd,
      StGap,
      StDone,
      StErr
`ifdef SCCB_CFG_DELAY_EN
      ,
      StDelay
`endif
   } seq_state_e;

   localparam logic [7:0] DELAY_TAG = 8'hFF;

   localparam int unsigned TAG_MSB  = 31;
   localparam int unsigned TAG_LSB  = 24;
   localparam int unsigned ID_MSB   = 23;
   localparam int unsigned ID_LSB   = 16;
   localparam int unsigned REG_MSB  = 15;
   localparam int unsigned REG_LSB  = 8;
   localparam int unsigned DATA_MSB = 7;
   localparam int unsigned DATA_LSB = 0;

endpackage

// File: rtl/sccb_cfg_seq_if.sv
// sccb_cfg_seq_if: bundles the register-table port and the SCCB write-engine
// handshake seen by the configuration sequencer.
//   cfg_index  table address          (sequencer -> table)
//   cfg_len    number of entries      (table -> sequencer)
//   cfg_entry  table word, sync read  (table -> sequencer)
//   wr_data    word for the engine    (sequencer -> engine)
//   wr_flag    one-cycle request      (sequencer -> engine)
//   wr_end     1 = engine idle        (engine -> sequencer)
// Modports: master = sequencer side, slave = table/engine side.
interface sccb_cfg_seq_if #(
   parameter int unsigned IDX_W = 8
);
   logic [IDX_W-1:0] cfg_index;
   logic [IDX_W-1:0] cfg_len;
   logic [31:0]      cfg_entry;
   logic [31:0]      wr_data;
   logic             wr_flag;
   logic             wr_end;

   modport master (
      output cfg_index,
      output wr_data,
      output wr_flag,
      input  cfg_len,
      input  cfg_entry,
      input  wr_end
   );

   modport slave (
      input  cfg_index,
      input  wr_data,
      input  wr_flag,
      output cfg_len,
      output cfg_entry,
      output wr_end
   );
endinterface

// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: walks a table of SCCB register writes once per start, issuing
// each entry to the SCCB write engine through the wr_flag/wr_end handshake, with
// a power-up delay, an inter-write gap and a per-write timeout.
//   axi_clk, axi_rst_n  clock, asynchronous active-low reset
//   start               pulse; begins a pass when not busy
//   busy / done / err   pass running / completed / aborted on timeout
//   err_index           index of the entry that timed out
//   bus                 table + engine handshake (sccb_cfg_seq_if.master)
// Optional feature macro: SCCB_CFG_DELAY_EN -- entries tagged DELAY_TAG in
// bits[31:24] become wait periods of entry[23:0] cycles instead of writes.
module sccb_cfg_seq
   import sccb_pkg::*;
#(
   parameter int unsigned IDX_W    = 8,
   parameter int unsigned BOOT_DLY = 100000,
   parameter int unsigned GAP_DLY  = 5000,
   parameter int unsigned TIMEOUT  = 1000000
) (
   input  logic             axi_clk,
   input  logic             axi_rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDX_W-1:0] err_index,
   sccb_cfg_seq_if.master   bus
);

   localparam logic [31:0] BootLast = 32'(BOOT_DLY - 1);
   localparam logic [31:0] GapLast  = 32'(GAP_DLY - 1);
   // ERR must be visible exactly TIMEOUT cycles after ISSUE; the counter is 0 in
   // the first wait cycle, so the abort decision is taken one count early.
   localparam logic [31:0] TmoLast  = 32'(TIMEOUT - 2);

   seq_state_e       state_q, state_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] len_q, len_d;
   logic [IDX_W-1:0] eidx_q, eidx_d;
   logic [31:0]      wdata_q, wdata_d;
`ifdef SCCB_CFG_DELAY_EN
   logic [23:0]      dly_q, dly_d;
`endif

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         eidx_q  <= '0;
         wdata_q <= '0;
`ifdef SCCB_CFG_DELAY_EN
         dly_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         eidx_q  <= eidx_d;
         wdata_q <= wdata_d;
`ifdef SCCB_CFG_DELAY_EN
         dly_q   <= dly_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 32'd1;
      idx_d   = idx_q;
      len_d   = len_q;
      eidx_d  = eidx_q;
      wdata_d = wdata_q;
`ifdef SCCB_CFG_DELAY_EN
      dly_d   = dly_q;
`endif

      unique case (state_q)
         StIdle, StDone, StErr: begin
            cnt_d = '0;
            if (start) begin
               len_d   = bus.cfg_len;
               idx_d   = '0;
               state_d = StBoot;
            end
         end

         StBoot: begin
            if (cnt_q == BootLast) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? StDone : StFetch;
            end
         end

         StFetch: begin
            cnt_d = '0;
`ifdef SCCB_CFG_DELAY_EN
            if (bus.cfg_entry[TAG_MSB:TAG_LSB] == DELAY_TAG) begin
               dly_d = bus.cfg_entry[ID_MSB:DATA_LSB];
               if (bus.cfg_entry[ID_MSB:DATA_LSB] == 24'd0) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = StGap;
               end else begin
                  state_d = StDelay;
               end
            end else begin
               wdata_d = bus.cfg_entry;
               state_d = StIssue;
            end
`else
            wdata_d = bus.cfg_entry;
            state_d = StIssue;
`endif
         end

         StIssue: begin
            cnt_d   = '0;
            state_d = StWaitAck;
         end

         // The counter keeps running from WAIT_ACK into WAIT_END: one budget per write.
         StWaitAck: begin
            if (!bus.wr_end) begin
               state_d = StWaitEnd;
            end else if (cnt_q == TmoLast) begin
               cnt_d   = '0;
               eidx_d  = idx_q;
               state_d = StErr;
            end
         end

         StWaitEnd: begin
            if (bus.wr_end) begin
               cnt_d   = '0;
               // Advance on GAP entry so a synchronous-read table has the whole gap
               // to present the next word before FETCH samples it.
               idx_d   = idx_q + IDX_W'(1);
               state_d = StGap;
            end else if (cnt_q == TmoLast) begin
               cnt_d   = '0;
               eidx_d  = idx_q;
               state_d = StErr;
            end
         end

         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d   = '0;
               state_d = (idx_q == len_q) ? StDone : StFetch;
            end
         end

`ifdef SCCB_CFG_DELAY_EN
         // Counter starts at 0, so DELAY spans dly+1 cycles including the handoff.
         StDelay: begin
            if (cnt_q == {8'd0, dly_q}) begin
               cnt_d   = '0;
               idx_d   = idx_q + IDX_W'(1);
               state_d = StGap;
            end
         end
`endif

         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // Decoded from the state register so wr_flag drops the moment reset asserts.
   assign bus.wr_flag   = (state_q == StIssue);
   assign bus.wr_data   = wdata_q;
   assign bus.cfg_index = idx_q;
   assign busy          = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
   assign done          = (state_q == StDone);
   assign err           = (state_q == StErr);
   assign err_index     = eidx_q;

endmodule
